// File: rtl/mem_responder_if.sv
// Request/response bundle between the MAR/MDR side and the memory responder.
// The master drives address, data and strobes; the slave answers with data and status.
interface mem_responder_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] Address;
    logic [DATA_WIDTH-1:0] DataIn;
    logic                  ReadEn;
    logic                  Write;
    logic [DATA_WIDTH-1:0] DataOut;
    logic                  Ready;
    logic                  Busy;
    logic                  Error;

    modport master (
        output Address, DataIn, ReadEn, Write,
        input  DataOut, Ready, Busy, Error
    );

    modport slave (
        input  Address, DataIn, ReadEn, Write,
        output DataOut, Ready, Busy, Error
    );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder: captures one read/write request, waits a fixed number of
// cycles, accesses the internal RAM and completes with a four-phase Ready handshake.
//
// state    | meaning
// S_IDLE   | waiting for exactly one strobe; both high pulses Error
// S_WAIT   | counting down wait states on the captured request
// S_ACCESS | single RAM access cycle; raises Ready
// S_DONE   | holds Ready until both strobes are sampled low
module mem_responder #(
    parameter int ADDR_WIDTH  = 9,
    parameter int DATA_WIDTH  = 32,
    parameter int WAIT_STATES = 2
) (
    input  logic           Clock,
    input  logic           Reset,
    mem_responder_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_DONE} state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  op_wr_q, op_wr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  ready_q, ready_d;
    logic                  busy_q, busy_d;
    logic                  error_q, error_d;

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        data_d     = data_q;
        op_wr_d    = op_wr_q;
        data_out_d = data_out_q;
        ready_d    = ready_q;
        busy_d     = busy_q;
        error_d    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.ReadEn && bus.Write) begin
                    error_d = 1'b1;
                end else if (bus.ReadEn || bus.Write) begin
                    addr_d  = bus.Address;
                    data_d  = bus.DataIn;
                    op_wr_d = bus.Write;
                    busy_d  = 1'b1;
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_ACCESS: begin
                if (!op_wr_q) begin
                    data_out_d = mem[addr_q];
                end
                ready_d = 1'b1;
                busy_d  = 1'b0;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!bus.ReadEn && !bus.Write) begin
                    ready_d = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            data_q     <= '0;
            op_wr_q    <= 1'b0;
            data_out_q <= '0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            op_wr_q    <= op_wr_d;
            data_out_q <= data_out_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
        end
    end

    // RAM has no reset so its contents survive a mid-transfer reset.
    always_ff @(posedge Clock) begin
        if (state_q == S_ACCESS && op_wr_q) begin
            mem[addr_q] <= data_q;
        end
    end

    assign bus.DataOut = data_out_q;
    assign bus.Ready   = ready_q;
    assign bus.Busy    = busy_q;
    assign bus.Error   = error_q;
endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance with two wait states, one with none.
module tb_mem_responder;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mem_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) if2 ();
    mem_responder_if #(.ADDR_WIDTH(9), .DATA_WIDTH(32)) if0 ();

    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(2)) u_ws2 (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (if2.slave)
    );

    mem_responder #(.ADDR_WIDTH(9), .DATA_WIDTH(32), .WAIT_STATES(0)) u_ws0 (
        .Clock (clk),
        .Reset (rst_n),
        .bus   (if0.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Full transfer on the two-wait-state instance with a bounded wait for Ready.
    task automatic ws2_xfer(input logic wr, input logic [8:0] a, input logic [31:0] d);
        int n;
        if2.Address = a;
        if2.DataIn  = d;
        if2.ReadEn  = !wr;
        if2.Write   = wr;
        n = 0;
        do begin
            step();
            n++;
        end while (if2.Ready !== 1'b1 && n < 20);
        chk("xfer_ready", {31'd0, if2.Ready}, 32'd1);
        chk("xfer_latency", n, 32'd4);
        if2.ReadEn = 1'b0;
        if2.Write  = 1'b0;
        step();
        chk("xfer_release", {31'd0, if2.Ready}, 32'd0);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        if2.Address = '0; if2.DataIn = '0; if2.ReadEn = 1'b0; if2.Write = 1'b0;
        if0.Address = '0; if0.DataIn = '0; if0.ReadEn = 1'b0; if0.Write = 1'b0;
        step();
        step();
        chk("rst_ready2", {31'd0, if2.Ready}, 32'd0);
        chk("rst_busy2",  {31'd0, if2.Busy},  32'd0);
        chk("rst_error2", {31'd0, if2.Error}, 32'd0);
        chk("rst_dout2",  if2.DataOut,        32'd0);
        chk("rst_ready0", {31'd0, if0.Ready}, 32'd0);
        chk("rst_dout0",  if0.DataOut,        32'd0);
        rst_n = 1'b1;
        step();

        // Write 0xDEADBEEF to 0x05, checking each cycle of the latency.
        if2.Address = 9'h005; if2.DataIn = 32'hDEADBEEF; if2.Write = 1'b1;
        step();
        chk("t1_cap_busy",  {31'd0, if2.Busy},  32'd1);
        chk("t1_cap_ready", {31'd0, if2.Ready}, 32'd0);
        step();
        chk("t1_w1_ready",  {31'd0, if2.Ready}, 32'd0);
        step();
        chk("t1_w2_ready",  {31'd0, if2.Ready}, 32'd0);
        chk("t1_w2_busy",   {31'd0, if2.Busy},  32'd1);
        step();
        chk("t1_ready",     {31'd0, if2.Ready}, 32'd1);
        chk("t1_busy_done", {31'd0, if2.Busy},  32'd0);
        chk("t1_dout_wr",   if2.DataOut,        32'd0);
        step();
        chk("t1_hold",      {31'd0, if2.Ready}, 32'd1);
        if2.Write = 1'b0;
        step();
        chk("t1_drop",      {31'd0, if2.Ready}, 32'd0);
        if2.ReadEn = 1'b1;
        step();
        step();
        step();
        chk("t1_rd_early",  {31'd0, if2.Ready}, 32'd0);
        step();
        chk("t1_rd_ready",  {31'd0, if2.Ready}, 32'd1);
        chk("t1_rd_data",   if2.DataOut,        32'hDEADBEEF);
        if2.ReadEn = 1'b0;
        step();
        chk("t1_rd_drop",   {31'd0, if2.Ready}, 32'd0);

        // Zero wait states, top address.
        if0.Address = 9'h1FF; if0.DataIn = 32'h12345678; if0.Write = 1'b1;
        step();
        chk("t2_wr_busy",   {31'd0, if0.Busy},  32'd1);
        chk("t2_wr_nrdy",   {31'd0, if0.Ready}, 32'd0);
        step();
        chk("t2_wr_ready",  {31'd0, if0.Ready}, 32'd1);
        if0.Write = 1'b0;
        step();
        chk("t2_wr_drop",   {31'd0, if0.Ready}, 32'd0);
        if0.ReadEn = 1'b1;
        step();
        chk("t2_rd_nrdy",   {31'd0, if0.Ready}, 32'd0);
        step();
        chk("t2_rd_ready",  {31'd0, if0.Ready}, 32'd1);
        chk("t2_rd_data",   if0.DataOut,        32'h12345678);
        if0.ReadEn = 1'b0;
        step();

        // Both strobes high in IDLE for three cycles.
        ws2_xfer(1'b1, 9'h00A, 32'hA5A5A5A5);
        if2.Address = 9'h00A; if2.DataIn = 32'h0; if2.ReadEn = 1'b1; if2.Write = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t3_error", {31'd0, if2.Error}, 32'd1);
            chk("t3_busy",  {31'd0, if2.Busy},  32'd0);
            chk("t3_ready", {31'd0, if2.Ready}, 32'd0);
        end
        if2.ReadEn = 1'b0; if2.Write = 1'b0;
        step();
        chk("t3_error_off", {31'd0, if2.Error}, 32'd0);
        ws2_xfer(1'b0, 9'h00A, 32'h0);
        chk("t3_ram_kept",  if2.DataOut, 32'hA5A5A5A5);

        // Reset during WAIT discards the write.
        if2.Address = 9'h00A; if2.DataIn = 32'h11111111; if2.Write = 1'b1;
        step();
        chk("t4_busy", {31'd0, if2.Busy}, 32'd1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t4_rst_busy",  {31'd0, if2.Busy},  32'd0);
        chk("t4_rst_ready", {31'd0, if2.Ready}, 32'd0);
        chk("t4_rst_error", {31'd0, if2.Error}, 32'd0);
        chk("t4_rst_dout",  if2.DataOut,        32'd0);
        if2.Write = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        ws2_xfer(1'b0, 9'h00A, 32'h0);
        chk("t4_ram_prior", if2.DataOut, 32'hA5A5A5A5);

        // ReadEn held long past Ready; address moves during DONE.
        if2.Address = 9'h005; if2.ReadEn = 1'b1;
        step();
        step();
        step();
        step();
        chk("t5_ready", {31'd0, if2.Ready}, 32'd1);
        chk("t5_data",  if2.DataOut,        32'hDEADBEEF);
        if2.Address = 9'h00A;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("t5_hold_ready", {31'd0, if2.Ready}, 32'd1);
            chk("t5_hold_busy",  {31'd0, if2.Busy},  32'd0);
            chk("t5_hold_data",  if2.DataOut,        32'hDEADBEEF);
        end
        if2.ReadEn = 1'b0;
        step();
        chk("t5_drop",    {31'd0, if2.Ready}, 32'd0);
        step();
        chk("t5_no_busy", {31'd0, if2.Busy},  32'd0);
        chk("t5_no_data", if2.DataOut,        32'hDEADBEEF);

        // ReadEn dropped during WAIT: Ready for exactly one cycle.
        if2.Address = 9'h00A; if2.ReadEn = 1'b1;
        step();
        if2.ReadEn = 1'b0;
        step();
        step();
        chk("t6_early", {31'd0, if2.Ready}, 32'd0);
        step();
        chk("t6_ready", {31'd0, if2.Ready}, 32'd1);
        chk("t6_data",  if2.DataOut,        32'hA5A5A5A5);
        step();
        chk("t6_pulse", {31'd0, if2.Ready}, 32'd0);
        step();
        chk("t6_idle_ready", {31'd0, if2.Ready}, 32'd0);
        chk("t6_idle_busy",  {31'd0, if2.Busy},  32'd0);
        ws2_xfer(1'b0, 9'h005, 32'h0);
        chk("t6_next_read", if2.DataOut, 32'hDEADBEEF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
